// File: rtl/pipelined_adder_if.sv
// Streaming handshake bundle for pipelined_adder: operand side (in_*) and result side (out_*).
// The sub select only exists when ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // master feeds operands and consumes results; slave is the adder itself
  modport master (
`ifdef ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
`ifdef ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: a WIDTH-bit add split into STAGES chunks, carry registered between stages.
// Define ADDER_SUB_EN to enable the per-transaction subtract select (bus.sub).
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);

  localparam int SAFE_STAGES = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK       = WIDTH / SAFE_STAGES;
  localparam int LAST        = SAFE_STAGES - 1;
  localparam int MSB         = WIDTH - 1;

  if ((STAGES < 1) || ((WIDTH % SAFE_STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH (%0d) must be a multiple of STAGES (%0d), STAGES >= 1",
           WIDTH, STAGES);
  end

  logic [SAFE_STAGES-1:0]            valid_q, valid_d;
  logic [SAFE_STAGES-1:0]            carry_q, carry_d;
  logic [SAFE_STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [SAFE_STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [SAFE_STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
  logic                              ovf_q, ovf_d;

  logic [SAFE_STAGES-1:0]            src_valid;
  logic [SAFE_STAGES-1:0]            src_carry;
  logic [SAFE_STAGES-1:0][WIDTH-1:0] src_a;
  logic [SAFE_STAGES-1:0][WIDTH-1:0] src_b;
  logic [SAFE_STAGES-1:0][WIDTH-1:0] src_sum;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             unused_last_operands;

  // Subtraction is folded in at the input so every stage only ever adds.
`ifdef ADDER_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  assign adv = !valid_q[LAST] || bus.out_ready;

  always_comb begin
    src_valid = '0;
    src_carry = '0;
    src_a     = '0;
    src_b     = '0;
    src_sum   = '0;
    src_valid[0] = bus.in_valid;
    src_carry[0] = cin_eff;
    src_a[0]     = bus.a;
    src_b[0]     = b_eff;
    for (int k = 1; k < SAFE_STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_sum[k]   = sum_q[k-1];
    end
  end

  // Whole pipeline moves in lockstep; operands ride along (skew) and finished chunks follow (deskew).
  always_comb begin : stage_adders
    logic [CHUNK:0] chunk_sum;
    chunk_sum = '0;
    valid_d   = valid_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    if (adv) begin
      for (int k = 0; k < SAFE_STAGES; k++) begin
        chunk_sum = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                  + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, src_carry[k]};
        valid_d[k] = src_valid[k];
        carry_d[k] = chunk_sum[CHUNK];
        a_d[k]     = src_a[k];
        b_d[k]     = src_b[k];
        sum_d[k]   = src_sum[k];
        sum_d[k][k*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
      end
      ovf_d = (src_a[LAST][MSB] == src_b[LAST][MSB]) &&
              (sum_d[LAST][MSB] != src_a[LAST][MSB]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // The last stage's operand copies have no consumer downstream.
  assign unused_last_operands = ^{a_q[LAST], b_q[LAST]};

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = sum_q[LAST];
  assign bus.cout      = carry_q[LAST];
  assign bus.ovf       = ovf_q;

endmodule
